// File: rtl/score_to_lcd_digits.sv
// Score-to-LCD converter: a 16-bit binary score becomes five decimal character codes
// through serial double dabble. Optional leading-zero blanking; a read port selects one character.
module score_to_lcd_digits (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [15:0] value,
  input  logic        blank_en,
  input  logic [2:0]  rd_index,
  output logic [7:0]  rd_data,
  output logic        busy,
  output logic        done,
  output logic        valid
);

  typedef enum logic [1:0] {IDLE, SHIFT, FORMAT} state_t;

  localparam logic [7:0] CHAR_SPACE = 8'h5F;

  state_t          state, state_nx;
  logic [15:0]     bin_q;
  logic [19:0]     bcd_q;
  logic [19:0]     bcd_adj;
  logic [3:0]      iter_q;
  logic            blank_q;
  logic [4:0][7:0] chr_q;
  logic [4:0][7:0] chr_nx;
  logic            lead;
  logic [3:0]      digit;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = SHIFT;
      SHIFT:   if (iter_q == 4'd15) state_nx = FORMAT;
      FORMAT:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Add-3 correction applied to every BCD nibble before the shift
  always_comb begin
    bcd_adj = bcd_q;
    for (int unsigned i = 0; i < 5; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    end
  end

  // chr_nx[0] is D4, chr_nx[4] is D0; blanking runs from D4 down and stops at the first nonzero
  always_comb begin
    lead   = blank_q;
    digit  = '0;
    chr_nx = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      digit = bcd_q[4*(4-i) +: 4];
      if (lead && digit == 4'd0) begin
        chr_nx[i] = CHAR_SPACE;
      end else begin
        lead      = 1'b0;
        chr_nx[i] = {4'h1, digit};
      end
    end
    chr_nx[4] = {4'h1, bcd_q[3:0]};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bin_q   <= '0;
      bcd_q   <= '0;
      iter_q  <= '0;
      blank_q <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      valid   <= 1'b0;
      for (int unsigned i = 0; i < 5; i++) chr_q[i] <= CHAR_SPACE;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            bin_q   <= value;
            bcd_q   <= '0;
            iter_q  <= '0;
            blank_q <= blank_en;
            busy    <= 1'b1;
          end
        end
        SHIFT: begin
          bcd_q  <= {bcd_adj[18:0], bin_q[15]};
          bin_q  <= {bin_q[14:0], 1'b0};
          iter_q <= iter_q + 4'd1;
        end
        FORMAT: begin
          chr_q <= chr_nx;
          done  <= 1'b1;
          valid <= 1'b1;
          busy  <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    rd_data = '0;
    if (rd_index <= 3'd4) rd_data = chr_q[rd_index];
  end

endmodule

// File: doc/score_to_lcd_digits.md
SCORE_TO_LCD_DIGITS -- requirements
Module: score_to_lcd_digits

Interface
REQ-001 The block SHALL use a single clock and asynchronous active-low reset: clk input 1 (rising-edge clock); reset input 1 (asynchronous, active-low).
REQ-002 The block SHALL provide start input 1 (conversion request, level-sampled each clk edge).
REQ-003 The block SHALL provide value input 16 (unsigned binary score, sampled on the accepting edge).
REQ-004 The block SHALL provide blank_en input 1 (leading-zero blanking enable, sampled on the accepting edge).
REQ-005 The block SHALL provide rd_index input 3 (character select for the downstream LCD writer).
REQ-006 The block SHALL provide rd_data output 8 (LCD character code for rd_index).
REQ-007 The block SHALL provide busy output 1 (conversion in progress).
REQ-008 The block SHALL provide done output 1 (one-cycle completion pulse).
REQ-009 The block SHALL provide valid output 1 (at least one conversion has completed since reset).

Function
REQ-010 The block SHALL convert value to five decimal digits, D4 (ten-thousands) to D0 (units), by iterative shift-and-add-3 (double dabble), one bit per clk.
REQ-011 The FSM SHALL have the states IDLE, SHIFT and FORMAT; the reset state SHALL be IDLE.
REQ-012 In IDLE, start=1 at edge N SHALL load value into the shift register, clear the 20-bit BCD accumulator, capture blank_en, set busy=1 and enter SHIFT.
REQ-013 SHIFT SHALL perform exactly 16 iterations on edges N+1..N+16; before each shift, every BCD nibble >= 5 SHALL be incremented by 3.
REQ-014 After the 16th iteration the FSM SHALL enter FORMAT; edge N+17 SHALL write all five character registers at once, pulse done=1 for exactly one cycle, set valid=1, clear busy to 0, and return to IDLE.
REQ-015 Latency from the accepting edge to the done pulse SHALL be 17 clk; busy SHALL be high for exactly 17 cycles.
REQ-016 The digit character code SHALL be 8'h10 + digit (range 8'h10..8'h19).
REQ-017 With captured blank_en=1, each leading zero digit among D4..D1 SHALL be coded 8'h5F (space); blanking SHALL stop at the first nonzero digit; D0 SHALL never be blanked.
REQ-018 With captured blank_en=0, all five digits SHALL use REQ-016 coding.
REQ-019 rd_data SHALL be combinational from the character registers: rd_index 0..4 select D4..D0; rd_index 5..7 SHALL give 8'h00.
REQ-020 The character registers SHALL hold the previous result throughout a conversion; no partial result SHALL ever be visible on rd_data.
REQ-021 start while busy=1 SHALL be ignored, with no queuing.
REQ-022 start=1 during the done cycle SHALL be accepted, because the FSM is in IDLE; back-to-back conversions SHALL therefore repeat every 18 cycles.
REQ-023 value and blank_en changes after the accepting edge SHALL have no effect on the conversion in progress.

Reset
REQ-024 Asserting reset (low) SHALL immediately force the following, regardless of state, including mid-conversion: state=IDLE; busy=0; done=0; valid=0; all character registers=8'h5F; shift register and BCD accumulator=0; captured blank_en=0.
REQ-025 An aborted conversion SHALL produce no done pulse; the first start accepted after reset release SHALL begin a fresh conversion.

Verification
REQ-026 value=0, blank_en=1, start pulse -> done 17 clk later; rd_index 0..4 read 5F,5F,5F,5F,10; valid=1.
REQ-027 value=65535, blank_en=0 -> rd_index 0..4 read 16,15,15,13,15; rd_index 7 reads 00.
REQ-028 value=1234 with blank_en=0 -> 10,11,12,13,14; with blank_en=1 -> 5F,11,12,13,14.
REQ-029 start held high continuously with value toggling -> exactly one done per 18 cycles, each result matching the value present at its accepting edge; busy high 17 of every 18 cycles.
REQ-030 value=99 converted, then value=500 started, reset asserted at SHIFT iteration 8 -> busy=0, valid=0, all reads 5F (index 5..7 read 00), no done; after release, value=7 with blank_en=1 -> 5F,5F,5F,5F,17.
REQ-031 Sample rd_data at every cycle during a conversion following a prior result of 42 -> the prior result's codes remain stable until the done edge.
